// File: rtl/threshold_table_loader_pkg.sv
// threshold_table_loader_pkg: FSM encoding and derived table geometry shared with the comparator
package threshold_table_loader_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_INIT, ST_WRITE, ST_VERIFY, ST_DONE} state_t;
  function automatic int cnt_width(input int vw);
    return $clog2(vw);
  endfunction
  function automatic int depth(input int vw);
    return 2 * vw + 1;
  endfunction
  function automatic int addr_width(input int vw);
    return $clog2(2 * vw + 1);
  endfunction
endpackage

// File: rtl/threshold_table_loader_step_gen.sv
// threshold_step_gen: steps q = ceil(num*s/sum) one s at a time using a running remainder
module threshold_step_gen #(
  parameter int THRESH_WIDTH = 8,
  parameter int DATA_WIDTH = 7,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    restart,
  input  logic                    advance,
  input  logic [THRESH_WIDTH-1:0] num,
  input  logic [THRESH_WIDTH:0]   sum,
  output logic [DATA_WIDTH-1:0]   q,
  output logic [ADDR_WIDTH-1:0]   s
);
  logic signed [THRESH_WIDTH+1:0] r, r_sub;
  // r = q*sum - num*s stays in [0, sum), so a single conditional add replaces division
  assign r_sub = r - $signed({2'b00, num});
  always_ff @(posedge clk) begin
    if (!rstn || restart) begin
      q <= '0;
      r <= '0;
      s <= '0;
    end else if (advance) begin
      q <= r_sub[THRESH_WIDTH+1] ? q + 1'b1 : q;
      r <= r_sub[THRESH_WIDTH+1] ? r_sub + $signed({1'b0, sum}) : r_sub;
      s <= s + 1'b1;
    end
  end
endmodule

// File: rtl/threshold_table_loader.sv
// threshold_table_loader: fills the Tanimoto threshold table, one entry per union popcount.
// Define THRESH_READBACK_EN to add a read-back verify pass after the write pass.
module threshold_table_loader
  import threshold_table_loader_pkg::*;
#(
  parameter int VECTOR_WIDTH = 35,
  parameter int THRESH_WIDTH = 8,
  parameter int CNT_WIDTH = cnt_width(VECTOR_WIDTH),
  parameter int DATA_WIDTH = CNT_WIDTH + 1,
  parameter int DEPTH = depth(VECTOR_WIDTH),
  parameter int ADDR_WIDTH = addr_width(VECTOR_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_Start,
  input  logic [THRESH_WIDTH-1:0] i_ThreshNum,
  input  logic [THRESH_WIDTH-1:0] i_ThreshDen,
  output logic [ADDR_WIDTH-1:0]   o_BRAM_Addr,
  output logic [DATA_WIDTH-1:0]   o_BRAM_Din,
  output logic                    o_BRAM_WrEn,
  output logic                    o_BRAM_En,
  input  logic [DATA_WIDTH-1:0]   i_BRAM_Dout,
  output logic                    o_Busy,
  output logic                    o_Done,
  output logic                    o_Error
);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
  state_t state, next;
  logic [THRESH_WIDTH-1:0] num, den;
  logic [THRESH_WIDTH:0] sum;
  logic err, bad, start_ok, last_wr, wr, rd, restart, advance;
  logic [DATA_WIDTH-1:0] q;
  logic [ADDR_WIDTH-1:0] s;
  assign bad = (i_ThreshNum > i_ThreshDen) || (i_ThreshNum == '0 && i_ThreshDen == '0);
  assign start_ok = state == ST_IDLE && i_Start;
  assign wr = state == ST_WRITE;
  assign last_wr = wr && s == LAST;
`ifdef THRESH_READBACK_EN
  localparam logic [ADDR_WIDTH-1:0] ENDV = ADDR_WIDTH'(DEPTH);
  logic [DATA_WIDTH-1:0] exp_q;
  assign rd = state == ST_VERIFY && s < ENDV;
  assign restart = state == ST_INIT || last_wr;
  assign advance = wr || rd;
  // read data lags the address by one cycle, so compare against last cycle's q
  always_ff @(posedge clk) exp_q <= !rstn ? '0 : q;
`else
  logic unused_dout;
  assign unused_dout = ^i_BRAM_Dout;
  assign rd = 1'b0;
  assign restart = state == ST_INIT;
  assign advance = wr;
`endif
  threshold_step_gen #(
    .THRESH_WIDTH(THRESH_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_step (
    .clk(clk),
    .rstn(rstn),
    .restart(restart),
    .advance(advance),
    .num(num),
    .sum(sum),
    .q(q),
    .s(s)
  );
  always_comb begin
    next = state;
    case (state)
      ST_IDLE: next = i_Start ? (bad ? ST_DONE : ST_INIT) : ST_IDLE;
      ST_INIT: next = ST_WRITE;
`ifdef THRESH_READBACK_EN
      ST_WRITE: next = last_wr ? ST_VERIFY : ST_WRITE;
      ST_VERIFY: next = (s == ENDV) ? ST_DONE : ST_VERIFY;
`else
      ST_WRITE: next = last_wr ? ST_DONE : ST_WRITE;
`endif
      default: next = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= ST_IDLE;
      num <= '0;
      den <= '0;
      sum <= '0;
      err <= 1'b0;
    end else begin
      state <= next;
      if (start_ok) begin
        num <= i_ThreshNum;
        den <= i_ThreshDen;
        err <= bad;
      end
      if (state == ST_INIT) sum <= {1'b0, num} + {1'b0, den};
`ifdef THRESH_READBACK_EN
      if (state == ST_VERIFY && s != '0 && i_BRAM_Dout != exp_q) err <= 1'b1;
`endif
    end
  end
  assign o_BRAM_En = wr || rd;
  assign o_BRAM_WrEn = wr;
  assign o_BRAM_Addr = (wr || rd) ? s : '0;
  assign o_BRAM_Din = wr ? q : '0;
  assign o_Busy = state != ST_IDLE;
  assign o_Done = state == ST_DONE;
  assign o_Error = err;
endmodule

// File: tb/tb_threshold_table_loader.sv
// tb_threshold_table_loader: scoreboard bench; expected table entries come from ceil(num*s/(num+den))
module tb_threshold_table_loader;
  localparam int VW = 35, TW = 8, DEPTH = 2 * VW + 1, AW = $clog2(DEPTH), DW = $clog2(VW) + 1;
`ifdef THRESH_READBACK_EN
  localparam int LAT = 2 * DEPTH + 3;
`else
  localparam int LAT = DEPTH + 2;
`endif
  logic clk = 0, rstn = 0, i_Start = 0, corrupt = 0;
  logic [TW-1:0] i_ThreshNum = 0, i_ThreshDen = 0;
  logic [AW-1:0] o_BRAM_Addr;
  logic [DW-1:0] o_BRAM_Din, i_BRAM_Dout = 0;
  logic o_BRAM_WrEn, o_BRAM_En, o_Busy, o_Done, o_Error;
  logic [DW-1:0] mem [DEPTH];
  int total = 0, bad = 0, cyc = 0, st = 0;
  typedef struct {int addr; int data;} wr_t;
  wr_t sb[$];

  threshold_table_loader dut (
    .clk(clk), .rstn(rstn), .i_Start(i_Start), .i_ThreshNum(i_ThreshNum), .i_ThreshDen(i_ThreshDen),
    .o_BRAM_Addr(o_BRAM_Addr), .o_BRAM_Din(o_BRAM_Din), .o_BRAM_WrEn(o_BRAM_WrEn), .o_BRAM_En(o_BRAM_En),
    .i_BRAM_Dout(i_BRAM_Dout), .o_Busy(o_Busy), .o_Done(o_Done), .o_Error(o_Error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk)
    if (o_BRAM_En) begin
      if (o_BRAM_WrEn) mem[o_BRAM_Addr] <= o_BRAM_Din;
      else i_BRAM_Dout <= mem[o_BRAM_Addr] ^ DW'(corrupt && o_BRAM_Addr == 33);
    end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk)
    if (o_BRAM_WrEn) begin
      wr_t e;
      if (sb.size() == 0) chk("unexpected_write_addr", int'(o_BRAM_Addr), -1);
      else begin
        e = sb.pop_front();
        chk("wr_addr", int'(o_BRAM_Addr), e.addr);
        chk("wr_data", int'(o_BRAM_Din), e.data);
      end
    end

  task automatic push(input int n, input int d);
    for (int s = 0; s < DEPTH; s++) sb.push_back('{s, (n * s + n + d - 1) / (n + d)});
  endtask

  task automatic kick(input int n, input int d);
    if (!(n > d || n + d == 0)) push(n, d);
    @(posedge clk);
    #1 i_Start = 1; i_ThreshNum = TW'(n); i_ThreshDen = TW'(d);
    @(posedge clk);
    #1 st = cyc; i_Start = 0;
  endtask

  task automatic run(input int n, input int d, input int err, input string tag, input int repulse);
    int w = 0;
    bit valid = !(n > d || n + d == 0);
    kick(n, d);
    @(negedge clk);
    chk({tag, "_busy"}, int'(o_Busy), 1);
    if (repulse > 0) begin
      repeat (repulse) @(posedge clk);
      #1 i_Start = 1; i_ThreshNum = 2;
      @(posedge clk);
      #1 i_Start = 0;
    end
    while (!o_Done && w < 400) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_done"}, int'(o_Done), 1);
    chk({tag, "_latency"}, cyc - st + 1, valid ? LAT : 1);
    chk({tag, "_error"}, int'(o_Error), err);
    chk({tag, "_writes_left"}, sb.size(), 0);
    @(negedge clk);
    chk({tag, "_idle_busy"}, int'(o_Busy), 0);
    chk({tag, "_sticky_error"}, int'(o_Error), err);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rstn = 1;
    @(negedge clk);
    chk("reset_busy", int'(o_Busy), 0);
    chk("reset_done", int'(o_Done), 0);
    chk("reset_error", int'(o_Error), 0);
    chk("reset_en", int'({o_BRAM_En, o_BRAM_WrEn}), 0);
    chk("reset_addr_din", int'({o_BRAM_Addr, o_BRAM_Din}), 0);
    run(1, 1, 0, "n1d1", 0);
    run(7, 10, 0, "n7d10", 0);
    run(0, 5, 0, "n0d5", 0);
    run(3, 2, 1, "num_gt_den", 0);
    run(0, 0, 1, "zero_sum", 0);
    run(5, 9, 0, "repulse", 10);
    kick(1, 3);
    repeat (21) @(posedge clk);
    #1 rstn = 0;
    @(posedge clk);
    #1 sb.delete(); rstn = 1;
    @(negedge clk);
    chk("abort_wren", int'(o_BRAM_WrEn), 0);
    chk("abort_busy", int'(o_Busy), 0);
    chk("abort_addr", int'(o_BRAM_Addr), 0);
    run(2, 3, 0, "after_abort", 0);
    run(255, 255, 0, "max", 0);
    for (int i = 0; i < 8; i++) begin
      int n, d;
      d = int'($urandom_range(0, 255));
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, d));
      run(n, d, (n > d || n + d == 0) ? 1 : 0, "rand", 0);
    end
`ifdef THRESH_READBACK_EN
    corrupt = 1;
    run(1, 1, 1, "corrupt", 0);
    corrupt = 0;
    run(4, 7, 0, "clean_verify", 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/threshold_table_loader.md
Name: threshold_table_loader

Overview:
- Writer side of the comparator's threshold BRAM port. Given a Tanimoto threshold t = NUM/DEN, it fills one table entry per possible union popcount s = a+b with the minimum intersection count c that passes.
- Passing condition: c/(s-c) >= NUM/DEN, which is equivalent to c >= ceil(NUM*s/(NUM+DEN)).
- Sits between the host/config logic and the comparator's i_BRAM_* inputs. Runs once per threshold change, before valid data flows.

Parameters:
- VECTOR_WIDTH, 35, fingerprint length in bits; must match the comparator.
- THRESH_WIDTH, 8, width of the NUM and DEN inputs.
- CNT_WIDTH, $clog2(VECTOR_WIDTH), derived; do not override.
- DATA_WIDTH, CNT_WIDTH+1, derived; table word width (matches comparator threshold width).
- DEPTH, 2*VECTOR_WIDTH+1, derived; entries for s = 0..2*VECTOR_WIDTH.
- ADDR_WIDTH, $clog2(DEPTH), derived.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- i_Start  in  1  single-cycle pulse; starts a load; honoured only in IDLE
- i_ThreshNum  in  THRESH_WIDTH  NUM; sampled on an accepted i_Start
- i_ThreshDen  in  THRESH_WIDTH  DEN; sampled on an accepted i_Start
- o_BRAM_Addr  out  ADDR_WIDTH  table address
- o_BRAM_Din  out  DATA_WIDTH  table write data
- o_BRAM_WrEn  out  1  write enable
- o_BRAM_En  out  1  port enable
- i_BRAM_Dout  in  DATA_WIDTH  read data, 1-cycle read latency; used only with readback
- o_Busy  out  1  high from the cycle after start acceptance through the o_Done cycle inclusive
- o_Done  out  1  one-cycle pulse when the load (and verify, if enabled) completes
- o_Error  out  1  sticky; cleared by reset or the next accepted i_Start

Behaviour:
- Reset: all outputs 0, FSM in IDLE. Reset mid-load aborts immediately; no further writes; table contents undefined.
- States: IDLE -> INIT -> WRITE -> (VERIFY) -> DONE -> IDLE.
- IDLE:
  - Accept i_Start; latch NUM and DEN; clear o_Error.
  - Latched NUM > DEN, or NUM+DEN == 0: go directly to DONE with o_Error=1 and no writes.
  - Otherwise go to INIT.
- INIT (1 cycle): compute SUM = NUM+DEN (THRESH_WIDTH+1 bits); set q=0, r=0, s=0.
- WRITE (DEPTH cycles): one write per cycle.
  - Drive o_BRAM_En=1, o_BRAM_WrEn=1, o_BRAM_Addr=s, o_BRAM_Din=q.
  - Then advance: r' = r - NUM; if r' < 0 then q += 1 and r' += SUM; s += 1.
  - r is signed, THRESH_WIDTH+2 bits; invariant 0 <= r < SUM. No divider is permitted.
  - q never exceeds VECTOR_WIDTH. On the last address (s = DEPTH-1), leave for VERIFY (if compiled in) or DONE.
- DONE (1 cycle): o_Done=1, o_BRAM_En=0, o_BRAM_WrEn=0. Return to IDLE.
- Latency: first write occurs 2 cycles after i_Start is sampled. o_Done occurs DEPTH+2 cycles after i_Start is sampled (no verify).
- i_Start while busy: ignored; latched NUM/DEN unchanged.
- Outside WRITE/VERIFY: o_BRAM_En=0, o_BRAM_WrEn=0, address and data held at 0.

Optional Feature:
- THRESH_READBACK_EN defined:
  - After WRITE, enter VERIFY: issue reads of addresses 0..DEPTH-1 (En=1, WrEn=0), one per cycle.
  - Regenerate the expected q with the same recurrence, delayed 1 cycle; compare against i_BRAM_Dout.
  - Any mismatch sets o_Error.
  - After the final compare (DEPTH+1 cycles in VERIFY), go to DONE.
- Undefined: no VERIFY state; i_BRAM_Dout is ignored (port still present); o_Error reflects only an invalid NUM/DEN.

Decomposition:
- Shared package: FSM state encoding; derived-width functions (CNT_WIDTH, DEPTH, ADDR_WIDTH), shared with the comparator.
- One sub-module, threshold_step_gen: holds q/r/s and steps the recurrence on an advance input, with a restart input. Instantiated once for WRITE and reused (restarted) for VERIFY expected-value generation.

Test Plan:
- NUM=1, DEN=1 -> writes addr 0..70; data = ceil(s/2): s=0->0, s=7->4, s=70->35. o_Done pulse at cycle start+73.
- NUM=7, DEN=10 -> s=17->7, s=18->8, s=70->29; exactly 71 WrEn cycles, addresses strictly increasing.
- NUM=0, DEN=5 -> all 71 entries written as 0; o_Error=0.
- NUM=3, DEN=2 (NUM>DEN) -> no WrEn; o_Done 1 cycle after idle transition; o_Error=1 until next valid start.
- i_Start re-pulsed at write 10 with NUM=2 -> ignored, table still matches the first NUM. rstn low at write 20 -> WrEn=0 the next cycle, all outputs 0, a new start afterwards is accepted normally.
- THRESH_READBACK_EN with BRAM model, corrupt addr 33 after write -> o_Error=1 at DONE. Uncorrupted run -> o_Error=0, o_Done at start+DEPTH+DEPTH+3.
